// File: rtl/exe_muldiv.sv
// exe_muldiv: RV32M/RV64M multiply/divide unit. A pipelined multiplier and an optional
// iterative restoring divider share one writeback port. Define MULDIV_DIV_EN to build the divider.
module exe_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3,
    parameter int REG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [REG_W-1:0] in_rd,
    output logic             wb_valid,
    output logic             wb_register_write,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_result
);

    logic                               accept;
    logic                               acc_mul;
    logic signed [XLEN:0]               a_q;
    logic signed [XLEN:0]               b_q;
    logic                               hi_q;
    logic                               zero_q;
    logic [2*XLEN-1:0]                  prod;
    logic [XLEN-1:0]                    prod_res;
    logic [MUL_LATENCY:1]               vld_pipe;
    logic [MUL_LATENCY:1][REG_W-1:0]    rd_pipe;
    logic [MUL_LATENCY:2][XLEN-1:0]     res_pipe;
    logic                               div_vld;
    logic [REG_W-1:0]                   div_rd;
    logic [XLEN-1:0]                    div_res;

    assign accept = in_valid & in_ready;

    // Stage 1 holds the XLEN+1 extended operands; the product is formed between stages 1 and 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (acc_mul) begin
            a_q    <= {((in_op == 3'd1) || (in_op == 3'd2)) & in_rs1[XLEN-1], in_rs1};
            b_q    <= {(in_op == 3'd1) & in_rs2[XLEN-1], in_rs2};
            hi_q   <= (in_op[1:0] != 2'd0);
            zero_q <= in_op[2];
        end
    end

    assign prod     = (2*XLEN)'(a_q * b_q);
    assign prod_res = zero_q ? '0 : (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
            res_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc_mul;
            rd_pipe[1]  <= in_rd;
            res_pipe[2] <= prod_res;
            for (int i = 2; i <= MUL_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
            for (int i = 3; i <= MUL_LATENCY; i++) res_pipe[i] <= res_pipe[i-1];
            if (flush) vld_pipe <= '0;
        end
    end

`ifdef MULDIV_DIV_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            q_neg, r_neg, is_rem;
    logic            acc_div, sgn, neg_a, neg_b;
    logic [XLEN:0]   shifted, diff;

    // DIV/REM have funct3[0] clear; the unsigned variants set it.
    assign sgn     = ~in_op[0];
    assign neg_a   = sgn & in_rs1[XLEN-1];
    assign neg_b   = sgn & in_rs2[XLEN-1];
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    // A divide waits for the multiplier to drain so the two never reach writeback together.
    assign in_ready = ~flush & (state == IDLE) & ~(in_op[2] & (|vld_pipe));
    assign acc_mul  = accept & ~in_op[2];
    assign acc_div  = accept & in_op[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_rem  <= 1'b0;
            div_vld <= 1'b0;
            div_rd  <= '0;
            div_res <= '0;
        end else if (flush) begin
            state   <= IDLE;
            div_vld <= 1'b0;
        end else begin
            div_vld <= 1'b0;
            case (state)
                IDLE: if (acc_div) begin
                    div_rd <= in_rd;
                    is_rem <= in_op[1];
                    if (in_rs2 == '0) begin
                        quo   <= '1;
                        rem   <= in_rs1;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                        state <= DONE;
                    end else if (sgn && in_rs1 == XMIN && in_rs2 == '1) begin
                        quo   <= XMIN;
                        rem   <= '0;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                        state <= DONE;
                    end else begin
                        quo   <= neg_a ? -in_rs1 : in_rs1;
                        dvs   <= neg_b ? -in_rs2 : in_rs2;
                        rem   <= '0;
                        q_neg <= neg_a ^ neg_b;
                        r_neg <= neg_a;
                        cnt   <= CW'(XLEN-1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= DONE;
                end
                DONE: begin
                    div_res <= is_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
                    div_vld <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = ~flush;
    assign acc_mul  = accept;
    assign div_vld  = 1'b0;
    assign div_rd   = '0;
    assign div_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
        end else if (!flush && vld_pipe[MUL_LATENCY]) begin
            wb_valid  <= 1'b1;
            wb_rd     <= rd_pipe[MUL_LATENCY];
            wb_result <= res_pipe[MUL_LATENCY];
        end else if (!flush && div_vld) begin
            wb_valid  <= 1'b1;
            wb_rd     <= div_rd;
            wb_result <= div_res;
        end else begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
        end
    end

    assign wb_register_write = wb_valid;

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised integer multiply/divide execution unit for the RV32M/RV64M extension. It sits between the dispatcher and writeback and supersedes the single-width multiply-only unit. Multiplies run through a fully pipelined signed multiplier with configurable latency and accept one op per cycle. Divides and remainders run on an iterative radix-2 restoring divider with a ready handshake. Both paths share one writeback port, and the unit guarantees they never collide.

## Interface
- XLEN, 32: operand/result width (32 or 64)
- MUL_LATENCY, 3: cycles from multiply acceptance to `wb_valid`, minimum 2
- REG_W, 5: destination register index width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill all in-flight ops (branch mispredict/exception)
- in_valid  in  1  dispatcher presents an op
- in_ready  out  1  unit accepts op this cycle (combinational on `in_op` and state)
- in_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1, in_rs2  in  XLEN  operands
- in_rd  in  REG_W  destination register
- wb_valid  out  1  result valid, one-cycle pulse per op
- wb_register_write  out  1  high whenever `wb_valid` is high
- wb_rd  out  REG_W  destination
- wb_result  out  XLEN  result

## Operation
- Accept on `in_valid & in_ready` at a rising edge.
- **Multiply path**
  - Operands are extended to XLEN+1 bits. rs1 is sign-extended for MULH/MULHSU. rs2 is sign-extended for MULH only. All other operands are zero-extended.
  - MUL returns product[XLEN-1:0]. The others return product[2*XLEN-1:XLEN].
  - Metadata (valid, rd, lower/upper select) is delayed alongside the product.
- **Divide FSM: IDLE → BUSY → DONE → IDLE**
  - IDLE: on accepting a divide op, latch magnitudes, result signs, rd, and op kind.
  - Special case, divisor = 0: quotient = all ones, remainder = rs1. Go straight to DONE.
  - Special case, signed overflow (DIV/REM with rs1 = MIN, rs2 = −1): quotient = MIN, remainder = 0. Go straight to DONE.
  - Otherwise enter BUSY with iteration counter = XLEN−1.
  - BUSY: one restoring shift/subtract step per cycle. Decrement the counter. Go to DONE after the step at counter 0.
  - DONE: apply sign correction. Quotient is negated if operand signs differ (signed ops only). Remainder takes the sign of rs1. Drive writeback, then return to IDLE.
- **in_ready**
  - Multiply ops: high when the FSM is IDLE.
  - Divide ops: high when the FSM is IDLE and no multiply is in flight in the pipeline.
  - This rule guarantees a single writeback per cycle.
- **flush**
  - Clears every pipeline valid bit and forces the FSM to IDLE on the next edge.
  - No `wb_valid` is produced for killed ops.
  - An op presented in the same cycle as `flush` is not accepted: `in_ready` is low while `flush` is high.
- **rd = 0:** results are still produced. Writeback discards them.

## Timing
- **Reset values:** `wb_valid`, `wb_register_write`, `wb_rd`, `wb_result` are 0. FSM is IDLE, pipeline valids are 0, `in_ready` is high.
- **Multiply:** accepted at edge k, `wb_valid` is high after edge k+MUL_LATENCY. Throughput is 1 per cycle, with back-to-back ops producing back-to-back results.
- **Divide, normal:** accepted at edge k. BUSY covers edges k+1..k+XLEN, DONE follows, and `wb_valid` is high after edge k+XLEN+2.
- **Divide, special case:** `wb_valid` is high after edge k+2.
- **Next divide:** may be accepted in the cycle `wb_valid` of the previous divide is high, because the FSM is IDLE again that cycle.
- **Reset mid-operation:** the asynchronous reset drops everything immediately. No stale `wb_valid` follows.

## Configuration
- **`MULDIV_DIV_EN` defined:** the divider and FSM are compiled in, as described above.
- **`MULDIV_DIV_EN` undefined:** the divider is removed.
  - Divide opcodes are accepted like multiplies and travel the multiply pipeline.
  - They write back `wb_result` = 0 after MUL_LATENCY.
  - `in_ready` depends only on `flush`.
  - The dispatcher must not rely on divide results in this build.

## Test plan
- **MUL/MULH/MULHSU/MULHU (XLEN=32)** with rs1=0xFFFFFFFF, rs2=0x00000002 → 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001, each exactly MUL_LATENCY cycles after accept.
- **Four back-to-back MULs** with rd=1..4 → four consecutive `wb_valid` pulses in order, with rd 1..4.
- **DIV −7/2 and REM −7/2** → −3 (0xFFFFFFFD) and −1, with `wb_valid` after edge k+34 (XLEN=32). `in_ready` for a MUL presented during BUSY stays low.
- **DIVU x/0 and REM 0x80000000/−1** → 0xFFFFFFFF with REMU returning x; DIV 0x80000000/−1 → 0x80000000, REM → 0. Both complete in 2 cycles.
- **DIV issued while two MULs are in flight** → `in_ready` is low until the pipeline drains. Then the DIV is accepted, and no two `wb_valid` pulses coincide.
- **flush asserted mid-BUSY with one MUL in flight** → no `wb_valid` for either op. FSM is IDLE and `in_ready` is high the cycle after `flush` deasserts. Reset asserted mid-BUSY → all outputs are 0 immediately.
